// File: rtl/demux_reg_hs.sv
// Registered 1-to-N demultiplexer with valid/ready handshakes.
// Each output port has its own holding register, so a stalled port only blocks beats addressed to it.
module demux_reg_hs #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [WIDTH-1:0]     s_data_i,
  input  logic [$clog2(N)-1:0] sel_i,
  output logic [N-1:0]         m_valid_o,
  input  logic [N-1:0]         m_ready_i,
  output logic [WIDTH-1:0]     m_data_o [N],
  output logic                 drop_o,
  output logic [7:0]           drop_cnt_o
);

  // Handshake: a beat moves on a rising edge where valid && ready. Ready never depends on
  // valid. Once valid is raised, data is held until that edge.
  logic [N-1:0] sel_hit;
  logic [N-1:0] load;
  logic [N-1:0] drain;
  logic         sel_ok;
  logic         tgt_free;
  logic         accept;
  logic         drop_fire;

  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < N; k++) begin
      sel_hit[k] = (int'(sel_i) == k);
    end
  end

  assign sel_ok    = (int'(sel_i) < N);
  // The target slot can take a beat if it is empty or is being drained on this same edge.
  assign tgt_free  = |(sel_hit & (~m_valid_o | m_ready_i));
  assign s_ready_o = rst_n & (~sel_ok | tgt_free);
  assign accept    = s_valid_i & s_ready_o;
  assign load      = {N{accept}} & sel_hit;
  assign drain     = m_valid_o & m_ready_i;
  assign drop_fire = accept & ~sel_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_o  <= '0;
      for (int k = 0; k < N; k++) begin
        m_data_o[k] <= '0;
      end
      drop_o     <= 1'b0;
      drop_cnt_o <= 8'd0;
    end else begin
      for (int k = 0; k < N; k++) begin
        // Load wins over drain so a back-to-back stream leaves no bubble.
        if (load[k]) begin
          m_valid_o[k] <= 1'b1;
          m_data_o[k]  <= s_data_i;
        end else if (drain[k]) begin
          m_valid_o[k] <= 1'b0;
        end
      end
      drop_o <= drop_fire;
      if (drop_fire && (drop_cnt_o != 8'hFF)) begin
        drop_cnt_o <= drop_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_demux_reg_hs.sv
// Bench for demux_reg_hs: a 4-port instance fed by directed beats with a per-port expected queue,
// and a 3-port instance used for out-of-range selects and drop counting.
module tb_demux_reg_hs;

  logic       clk;
  logic       rst_n;

  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic [1:0] sel;
  logic [3:0] m_valid;
  logic [3:0] m_ready;
  logic [7:0] m_data [4];
  logic       drop;
  logic [7:0] drop_cnt;

  logic       s_valid3;
  logic       s_ready3;
  logic [7:0] s_data3;
  logic [1:0] sel3;
  logic [2:0] m_valid3;
  logic [2:0] m_ready3;
  logic [7:0] m_data3 [3];
  logic       drop3;
  logic [7:0] drop_cnt3;

  logic [7:0] exp_q [4][$];
  int         checks;
  int         errors;
  logic       acc;

  demux_reg_hs #(.WIDTH(8), .N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .sel_i(sel),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
    .drop_o(drop), .drop_cnt_o(drop_cnt)
  );

  demux_reg_hs #(.WIDTH(8), .N(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid3), .s_ready_o(s_ready3), .s_data_i(s_data3), .sel_i(sel3),
    .m_valid_o(m_valid3), .m_ready_i(m_ready3), .m_data_o(m_data3),
    .drop_o(drop3), .drop_cnt_o(drop_cnt3)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Driver tasks: inputs change at posedge+1, the beat is judged at the following negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] p, input logic [7:0] d, output logic ok);
    s_valid = 1'b1;
    sel     = p;
    s_data  = d;
    @(negedge clk);
    ok = s_ready;
    if (ok) exp_q[p].push_back(d);
    tick();
  endtask

  task automatic send(input logic [1:0] p, input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) beat(p, d, ok);
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic idle();
    s_valid = 1'b0;
    tick();
  endtask

  // Monitor: every output handshake pops the port's expected queue.
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (m_valid[k] && m_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat port=%0d actual=%0h required=none", k, m_data[k]);
          end else begin
            e = exp_q[k].pop_front();
            check($sformatf("port%0d_data", k), {24'd0, m_data[k]}, {24'd0, e});
          end
        end
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    s_valid  = 1'b0; s_data  = 8'h00; sel  = 2'd0; m_ready  = 4'b1111;
    s_valid3 = 1'b0; s_data3 = 8'h00; sel3 = 2'd0; m_ready3 = 3'b111;

    // Reset state
    #12;
    check("rst_m_valid", {28'd0, m_valid}, 32'd0);
    check("rst_m_data2", {24'd0, m_data[2]}, 32'd0);
    check("rst_drop", {31'd0, drop}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single beat to port 2, delivered next cycle, then valid clears with data retained
    send(2'd2, 8'hA5);
    check("one_valid", {28'd0, m_valid}, 32'h4);
    check("one_data", {24'd0, m_data[2]}, 32'hA5);
    idle();
    check("one_valid_clr", {28'd0, m_valid}, 32'h0);
    check("one_data_keep", {24'd0, m_data[2]}, 32'hA5);

    // Backpressure on port 1, then simultaneous drain and reload
    m_ready = 4'b1101;
    send(2'd1, 8'h11);
    check("bp_valid1", {31'd0, m_valid[1]}, 32'd1);
    beat(2'd1, 8'h22, acc);
    check("bp_ready_low", {31'd0, acc}, 32'd0);
    check("bp_hold", {24'd0, m_data[1]}, 32'h11);
    m_ready = 4'b1111;
    beat(2'd1, 8'h22, acc);
    check("bp_ready_high", {31'd0, acc}, 32'd1);
    check("bp_no_bubble", {31'd0, m_valid[1]}, 32'd1);
    check("bp_new_data", {24'd0, m_data[1]}, 32'h22);
    idle();

    // Port 0 stalled and full; other ports keep streaming
    m_ready = 4'b1110;
    send(2'd0, 8'h30);
    for (int i = 0; i < 9; i++) begin
      beat(2'(1 + i % 3), 8'(8'h40 + i), acc);
      check("iso_accept", {31'd0, acc}, 32'd1);
      check("iso_valid", {31'd0, m_valid[1 + i % 3]}, 32'd1);
      check("iso_data", {24'd0, m_data[1 + i % 3]}, 32'(8'h40 + i));
      check("iso_port0", {23'd0, m_valid[0], m_data[0]}, 32'h130);
    end
    idle();
    m_ready = 4'b1111;
    tick();

    // Continuous stream to port 3
    for (int i = 0; i < 16; i++) begin
      beat(2'd3, 8'(i), acc);
      check("stream_accept", {31'd0, acc}, 32'd1);
      check("stream_valid", {31'd0, m_valid[3]}, 32'd1);
      check("stream_data", {24'd0, m_data[3]}, 32'(i));
    end
    idle();
    tick();

    // Reset mid-operation discards held beats
    m_ready = 4'b0000;
    send(2'd0, 8'h77);
    send(2'd2, 8'h88);
    check("pre_rst_valid", {28'd0, m_valid}, 32'h5);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {28'd0, m_valid}, 32'h0);
    check("mid_rst_data0", {24'd0, m_data[0]}, 32'h0);
    check("mid_rst_data2", {24'd0, m_data[2]}, 32'h0);
    check("mid_rst_ready", {31'd0, s_ready}, 32'd0);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 4'b1111;
    repeat (5) tick();
    check("post_rst_valid", {28'd0, m_valid}, 32'h0);

    // Out-of-range select on the 3-port instance
    s_valid3 = 1'b1; sel3 = 2'd3; s_data3 = 8'h5C;
    @(negedge clk);
    check("drop_ready", {31'd0, s_ready3}, 32'd1);
    tick();
    s_valid3 = 1'b0;
    check("drop_pulse", {31'd0, drop3}, 32'd1);
    check("drop_no_valid", {29'd0, m_valid3}, 32'd0);
    check("drop_cnt_one", {24'd0, drop_cnt3}, 32'd1);
    tick();
    check("drop_pulse_end", {31'd0, drop3}, 32'd0);
    check("drop_cnt_keep", {24'd0, drop_cnt3}, 32'd1);
    s_valid3 = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    check("drop_cnt_sat", {24'd0, drop_cnt3}, 32'd255);
    s_valid3 = 1'b0;
    tick();
    check("drop_sat_idle", {23'd0, drop3, drop_cnt3}, 32'd255);
    s_valid3 = 1'b1; sel3 = 2'd2; s_data3 = 8'h6D;
    tick();
    s_valid3 = 1'b0;
    check("n3_valid", {29'd0, m_valid3}, 32'h4);
    check("n3_data", {24'd0, m_data3[2]}, 32'h6D);
    check("n3_no_drop", {31'd0, drop3}, 32'd0);

    // Every accepted beat must have come out
    repeat (3) tick();
    for (int k = 0; k < 4; k++) check($sformatf("drained_q%0d", k), exp_q[k].size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_reg_hs.md
DEMUX_REG_HS -- requirements
Module: demux_reg_hs

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits.
REQ-002 Parameter N, default 4, number of output ports; N SHALL be >= 2.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port s_valid_i  input  1  input beat valid.
REQ-006 Port s_ready_o  output  1  block accepts input beat this cycle.
REQ-007 Port s_data_i  input  WIDTH  input beat payload.
REQ-008 Port sel_i  input  $clog2(N)  destination port index, sampled with the beat.
REQ-009 Port m_valid_o  output  N  per-port output valid.
REQ-010 Port m_ready_i  input  N  per-port downstream ready.
REQ-011 Port m_data_o  output  array [N] of WIDTH  per-port payload.
REQ-012 Port drop_o  output  1  one-cycle pulse: beat discarded, sel_i >= N.
REQ-013 Port drop_cnt_o  output  8  saturating count of dropped beats.

Function
REQ-014 Each output port SHALL own one holding register (data + valid flag).
REQ-015 Input handshake completes when s_valid_i && s_ready_o at a rising edge.
REQ-016 s_ready_o SHALL be combinational: 1 if sel_i >= N; else 1 if slot[sel_i] empty or (slot[sel_i] full and m_ready_i[sel_i]=1).
REQ-017 Accepted beat with sel_i < N SHALL be loaded into slot[sel_i]; m_valid_o[sel_i]=1 and m_data_o[sel_i]=s_data_i from the next cycle (latency 1).
REQ-018 Output handshake on port k completes when m_valid_o[k] && m_ready_i[k]; slot k then empties unless reloaded in the same cycle.
REQ-019 Simultaneous drain and load of the same slot SHALL keep m_valid_o[k]=1 and present the new data next cycle (full throughput, no bubble).
REQ-020 Slots SHALL drain independently; a stalled port SHALL NOT block beats addressed to other ports.
REQ-021 m_data_o[k] SHALL hold stable while m_valid_o[k]=1 and m_ready_i[k]=0.
REQ-022 Beat ordering per port SHALL be preserved; no beat duplicated or lost when sel_i < N.
REQ-023 Accepted beat with sel_i >= N SHALL be discarded: no slot change, drop_o=1 next cycle, drop_cnt_o incremented.
REQ-024 drop_cnt_o SHALL saturate at 255 and never wrap.
REQ-025 drop_o SHALL be 0 in every cycle not following a drop.
REQ-026 s_ready_o SHALL not depend on s_valid_i; changes to sel_i while s_valid_i=0 have no effect on state.
REQ-027 m_data_o[k] SHALL retain its last value after slot k empties (only m_valid_o[k] clears).

Reset
REQ-028 rst_n=0 SHALL, asynchronously and immediately, clear all m_valid_o to 0, m_data_o to 0, drop_o to 0, drop_cnt_o to 0.
REQ-029 Reset mid-operation SHALL discard all held beats; no beat held before reset appears after it.
REQ-030 Release of rst_n SHALL take effect on the next rising clk; first beat may be accepted in that cycle.
REQ-031 While rst_n=0, s_ready_o SHALL be 0.

Verification
REQ-032 Reset then one beat 0xA5, sel_i=2, m_ready_i=4'b1111 -> next cycle m_valid_o=4'b0100, m_data_o[2]=0xA5; cleared the cycle after.
REQ-033 m_ready_i[1]=0, send 0x11 to port 1 then 0x22 to port 1 -> s_ready_o=0 on second beat, m_data_o[1] stays 0x11; raise m_ready_i[1] -> 0x22 delivered next cycle, order 0x11,0x22.
REQ-034 Port 0 stalled and full, stream beats to ports 1..3 each cycle -> s_ready_o=1 throughout, all delivered with latency 1, port 0 unchanged.
REQ-035 N=3, beat with sel_i=3 -> s_ready_o=1, no m_valid_o rises, drop_o pulses one cycle, drop_cnt_o=1; 300 such beats -> drop_cnt_o=255.
REQ-036 Continuous beats to port 3 with m_ready_i[3]=1 -> one beat delivered per cycle, no bubbles, data matches sequence 0x00..0x0F.
REQ-037 Fill ports 0 and 2 under stall, assert rst_n=0 mid-cycle -> m_valid_o=0 immediately; after release, no stale data delivered.
